cla_pipe_adder: RTL

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder_pkg.sv | 13 +
 rtl/cla_pipe_adder_cla4_unit.sv | 26 ++
 rtl/cla_pipe_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Group size is fixed at 4 bits; WIDTH defaults to 16.
package cla_pipe_adder_pkg;

  localparam int GRP_W     = 4;
  localparam int DEF_WIDTH = 16;

  // Number of lookahead groups needed for a given operand width.
  function automatic int num_groups(input int width);
    return width / GRP_W;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_cla4_unit.sv
// 4-bit carry-lookahead cell: per-bit carries plus group generate/propagate.
// Purely combinational, so it adds no latency and has no backpressure.
module cla4_unit
  import cla_pipe_adder_pkg::*;
(
  input  logic [GRP_W-1:0] g,
  input  logic [GRP_W-1:0] p,
  input  logic             c_in,
  output logic [GRP_W-1:0] c,
  output logic             grp_g,
  output logic             grp_p
);

  // c[i] is the carry into bit i of the group, expanded flat with no ripple.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder: latency 2 cycles, one result per cycle.
// Valid/ready backpressure stalls both stages in place; in_ready is combinational from out_ready.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NGRP = num_groups(WIDTH);

  logic             s1_v_q,      s1_v_d;
  logic [WIDTH-1:0] s1_g_q,      s1_g_d;
  logic [WIDTH-1:0] s1_p_q,      s1_p_d;
  logic             s1_cin_q,    s1_cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;

  logic             s2_adv;
  logic             s1_load;
  logic [WIDTH-1:0] carry;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_load  = !s1_v_q || s2_adv;
  assign in_ready = rst || s1_load;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla4_unit u_cla4 (
      .g     (s1_g_q[k*GRP_W +: GRP_W]),
      .p     (s1_p_q[k*GRP_W +: GRP_W]),
      .c_in  (grp_c[k]),
      .c     (carry[k*GRP_W +: GRP_W]),
      .grp_g (grp_g[k]),
      .grp_p (grp_p[k])
    );
  end

  // Only the group carries ripple; bit carries come from each cla4_unit.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_cin_q;
    for (int k = 0; k < NGRP; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_g_d      = s1_g_q;
    s1_p_d      = s1_p_q;
    s1_cin_d    = s1_cin_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    if (s1_load) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_g_d   = A & B;
        s1_p_d   = A ^ B;
        s1_cin_d = Cin;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_v_q;
      if (s1_v_q) begin
        sum_d  = s1_p_q ^ carry;
        cout_d = grp_c[NGRP];
        ovf_d  = carry[WIDTH-1] ^ grp_c[NGRP];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_g_q      <= '0;
      s1_p_q      <= '0;
      s1_cin_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_g_q      <= s1_g_d;
      s1_p_q      <= s1_p_d;
      s1_cin_q    <= s1_cin_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule
